// File: rtl/ultra_sonic_multi.sv
// Multi-channel ultrasonic ranger: triggers NUM_CH HC-SR04-style sensors one at a
// time, times each synchronised echo in clk cycles and reports tagged results.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no scan; waiting for start
// ST_TRIG   | pulse_out[ch] high, TRIG_CYCLES long
// ST_WAIT   | waiting for a synced echo rise, bounded by TIMEOUT_CYCLES
// ST_MEAS   | counting cycles with synced echo high
// ST_RESULT | one-cycle result strobe
// ST_SETTLE | dead time before the next trigger or scan end
module ultra_sonic_multi #(
  parameter int NUM_CH         = 4,
  parameter int COUNT_W        = 23,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int SETTLE_CYCLES  = 3000000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset_all,
  input  logic               start,
  input  logic               continuous,
  input  logic [NUM_CH-1:0]  ch_enable,
  input  logic [NUM_CH-1:0]  echo_high,
  output logic [NUM_CH-1:0]  pulse_out,
  output logic               active_out,
  output logic               count_ready_out,
  output logic [CH_W-1:0]    count_ch_out,
  output logic [COUNT_W-1:0] count_out,
  output logic               timeout_out,
  output logic               scan_done_out
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TRIG   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_MEAS   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;
  localparam logic [2:0] ST_SETTLE = 3'd5;

  localparam int MAX_TS = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
  localparam int MAX_T  = (MAX_TS > TIMEOUT_CYCLES) ? MAX_TS : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0]   TRIG_LOAD   = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0]   WAIT_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TIMEOUT_VAL = COUNT_W'(TIMEOUT_CYCLES);
  localparam logic [COUNT_W-1:0] MEAS_LAST   = COUNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]         state;
  logic [TMR_W-1:0]   tmr;
  logic [COUNT_W-1:0] meas_cnt;
  logic [NUM_CH-1:0]  mask;
  logic [NUM_CH-1:0]  echo_s1;
  logic [NUM_CH-1:0]  echo_s2;
  logic [CH_W-1:0]    ch;
  logic               echo_prev;
  logic               echo_sel;
  logic               echo_rise;
  logic [CH_W-1:0]    first_ch;
  logic [CH_W-1:0]    next_ch;
  logic               next_found;

  assign echo_sel   = echo_s2[ch];
  assign echo_rise  = echo_sel & ~echo_prev;
  assign active_out = (state != ST_IDLE);

  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) first_ch = CH_W'(i);
      if (mask[i] && (i > int'(ch))) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    pulse_out = '0;
    if (state == ST_TRIG) pulse_out[ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state           <= ST_IDLE;
      tmr             <= '0;
      meas_cnt        <= '0;
      mask            <= '0;
      ch              <= '0;
      echo_s1         <= '0;
      echo_s2         <= '0;
      echo_prev       <= 1'b0;
      count_ready_out <= 1'b0;
      count_ch_out    <= '0;
      count_out       <= '0;
      timeout_out     <= 1'b0;
      scan_done_out   <= 1'b0;
    end else begin
      echo_s1         <= echo_high;
      echo_s2         <= echo_s1;
      // Tracks the selected line only; TRIG always precedes WAIT, so a channel
      // switch never fakes a rise.
      echo_prev       <= echo_sel;
      count_ready_out <= 1'b0;
      scan_done_out   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask <= ch_enable;
            if (ch_enable == '0) begin
              scan_done_out <= 1'b1;
            end else begin
              ch    <= first_ch;
              tmr   <= TRIG_LOAD;
              state <= ST_TRIG;
            end
          end
        end
        ST_TRIG: begin
          if (tmr == '0) begin
            tmr   <= WAIT_LOAD;
            state <= ST_WAIT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_WAIT: begin
          if (echo_rise) begin
            meas_cnt <= COUNT_W'(1);
            state    <= ST_MEAS;
          end else if (tmr == '0) begin
            count_ready_out <= 1'b1;
            count_ch_out    <= ch;
            count_out       <= TIMEOUT_VAL;
            timeout_out     <= 1'b1;
            state           <= ST_RESULT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_MEAS: begin
          if (!echo_sel) begin
            count_ready_out <= 1'b1;
            count_ch_out    <= ch;
            count_out       <= meas_cnt;
            timeout_out     <= 1'b0;
            state           <= ST_RESULT;
          end else if (meas_cnt == MEAS_LAST) begin
            // This cycle is the TIMEOUT_CYCLES-th high cycle.
            count_ready_out <= 1'b1;
            count_ch_out    <= ch;
            count_out       <= TIMEOUT_VAL;
            timeout_out     <= 1'b1;
            state           <= ST_RESULT;
          end else begin
            meas_cnt <= meas_cnt + COUNT_W'(1);
          end
        end
        ST_RESULT: begin
          tmr   <= SETTLE_LOAD;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end else if (next_found) begin
            ch    <= next_ch;
            tmr   <= TRIG_LOAD;
            state <= ST_TRIG;
          end else begin
            scan_done_out <= 1'b1;
            if (continuous && (ch_enable != '0)) begin
              mask  <= ch_enable;
              ch    <= first_ch;
              tmr   <= TRIG_LOAD;
              state <= ST_TRIG;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ultra_sonic_multi.sv
// Bench for ultra_sonic_multi: behavioural sensors plus an ordered scoreboard of
// expected results and scan-done markers.
module tb_ultra_sonic_multi;
  localparam int NUM_CH         = 4;
  localparam int COUNT_W        = 23;
  localparam int TRIG_CYCLES    = 10;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int SETTLE_CYCLES  = 20;
  localparam int CH_W           = 2;

  logic               clk = 1'b0;
  logic               reset_all;
  logic               start;
  logic               continuous;
  logic [NUM_CH-1:0]  ch_enable;
  logic [NUM_CH-1:0]  echo_high;
  logic [NUM_CH-1:0]  pulse_out;
  logic               active_out;
  logic               count_ready_out;
  logic [CH_W-1:0]    count_ch_out;
  logic [COUNT_W-1:0] count_out;
  logic               timeout_out;
  logic               scan_done_out;

  ultra_sonic_multi #(
    .NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .TRIG_CYCLES(TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .reset_all(reset_all), .start(start), .continuous(continuous),
    .ch_enable(ch_enable), .echo_high(echo_high), .pulse_out(pulse_out),
    .active_out(active_out), .count_ready_out(count_ready_out),
    .count_ch_out(count_ch_out), .count_out(count_out), .timeout_out(timeout_out),
    .scan_done_out(scan_done_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ch < 0 marks an expected scan_done
  typedef struct { int ch; int cnt; bit to; } res_t;
  res_t exp_q[$];

  int echo_dly[NUM_CH];
  int echo_len[NUM_CH];
  bit noise0 = 1'b0;

  function automatic res_t model(input int c);
    res_t r;
    r.ch = c;
    if (echo_len[c] == 0 || echo_len[c] >= TIMEOUT_CYCLES) begin
      r.cnt = TIMEOUT_CYCLES;
      r.to  = 1'b1;
    end else begin
      r.cnt = echo_len[c];
      r.to  = 1'b0;
    end
    return r;
  endfunction

  task automatic push_scan(input logic [NUM_CH-1:0] m);
    res_t mk;
    for (int c = 0; c < NUM_CH; c++)
      if (m[c]) exp_q.push_back(model(c));
    mk.ch = -1; mk.cnt = 0; mk.to = 1'b0;
    exp_q.push_back(mk);
  endtask

  // Sensors: echo starts echo_dly cycles after the trigger falls, lasts echo_len.
  int fall_cyc[NUM_CH];
  bit armed[NUM_CH];
  initial begin
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] ps;
    int scyc;
    scyc = 0;
    ps = '0;
    echo_high = '0;
    for (int c = 0; c < NUM_CH; c++) armed[c] = 1'b0;
    forever begin
      @(negedge clk);
      scyc++;
      ev = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (reset_all) armed[c] = 1'b0;
        else if (ps[c] && !pulse_out[c]) begin
          armed[c] = 1'b1;
          fall_cyc[c] = scyc;
        end
        if (armed[c]) begin
          if (scyc >= fall_cyc[c] + echo_dly[c] && scyc < fall_cyc[c] + echo_dly[c] + echo_len[c])
            ev[c] = 1'b1;
          else if (scyc >= fall_cyc[c] + echo_dly[c] + echo_len[c])
            armed[c] = 1'b0;
        end
      end
      if (noise0) ev[0] = 1'($urandom_range(0, 1));
      echo_high = ev;
      ps = pulse_out;
    end
  end

  // Monitor: scoreboard order, pulse width/channel, settle gap.
  int done_cnt = 0;
  initial begin
    int mcyc, run_len, last_res;
    logic [NUM_CH-1:0] pprev;
    res_t r;
    mcyc = 0; run_len = 0; last_res = -1000; pprev = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (reset_all) begin
        run_len = 0;
        pprev = '0;
      end else begin
        if (scan_done_out) begin
          check_val("done_order", (exp_q.size() > 0) ? exp_q[0].ch : -2, -1);
          if (exp_q.size() > 0 && exp_q[0].ch < 0) void'(exp_q.pop_front());
          done_cnt++;
        end
        if (count_ready_out) begin
          if (exp_q.size() == 0 || exp_q[0].ch < 0) check_val("res_unexp", count_ready_out, 0);
          else begin
            r = exp_q.pop_front();
            check_val("res_ch", count_ch_out, r.ch);
            check_val("res_count", count_out, r.cnt);
            check_val("res_timeout", timeout_out, r.to);
          end
          last_res = mcyc;
        end
        if (pulse_out != '0 && pprev == '0) begin
          check_val("pulse_onehot", $countones(pulse_out), 1);
          if (exp_q.size() > 0 && exp_q[0].ch >= 0)
            check_val("pulse_ch", pulse_out, 1 << exp_q[0].ch);
          else check_val("pulse_unexp", pulse_out, 0);
          check_val("settle_gap", (mcyc - last_res) >= SETTLE_CYCLES, 1);
        end
        if (pulse_out != '0) run_len++;
        else if (pprev != '0) begin
          check_val("pulse_width", run_len, TRIG_CYCLES);
          run_len = 0;
        end
        pprev = pulse_out;
      end
    end
  end

  task automatic check_zero(input string tag);
    check_val({tag, "_pulse"}, pulse_out, 0);
    check_val({tag, "_active"}, active_out, 0);
    check_val({tag, "_ready"}, count_ready_out, 0);
    check_val({tag, "_ch"}, count_ch_out, 0);
    check_val({tag, "_count"}, count_out, 0);
    check_val({tag, "_timeout"}, timeout_out, 0);
    check_val({tag, "_done"}, scan_done_out, 0);
  endtask

  task automatic set_sensor(input int c, input int d, input int l);
    echo_dly[c] = d;
    echo_len[c] = l;
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 1000 && echo_high != '0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_scan(input logic [NUM_CH-1:0] m, input logic [NUM_CH-1:0] mid_m);
    int d0;
    d0 = done_cnt;
    push_scan(m);
    @(negedge clk);
    ch_enable = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    ch_enable = mid_m;
    for (int i = 0; i < 6000 && done_cnt == d0; i++) @(negedge clk);
    check_val("scan_done_seen", done_cnt - d0, 1);
    @(negedge clk);
    check_val("active_after_scan", active_out, 0);
    wait_quiet();
  endtask

  initial begin
    int d0;
    logic seen;
    logic [NUM_CH-1:0] m;
    reset_all = 1'b1; start = 1'b0; continuous = 1'b0; ch_enable = '0;
    for (int c = 0; c < NUM_CH; c++) set_sensor(c, 10, 0);
    repeat (3) @(negedge clk);
    check_zero("por");
    reset_all = 1'b0;
    repeat (2) @(negedge clk);

    // single channel, 50-cycle echo
    set_sensor(0, 30, 50);
    run_scan(4'b0001, 4'b0001);

    // reset mid-measurement
    push_scan(4'b0001);
    @(negedge clk); ch_enable = 4'b0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    reset_all = 1'b1;
    @(negedge clk);
    check_zero("rst");
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset_all = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | active_out | count_ready_out | scan_done_out | (|pulse_out);
    end
    check_val("post_reset_idle", seen, 0);

    // two channels, noisy unselected ch0, mask change mid-scan
    set_sensor(1, 20, 40);
    set_sensor(3, 50, 70);
    noise0 = 1'b1;
    run_scan(4'b1010, 4'b1111);
    noise0 = 1'b0;
    wait_quiet();

    // timeouts: no echo, then echo too long
    set_sensor(2, 10, 0);
    run_scan(4'b0100, 4'b0100);
    set_sensor(2, 10, 500);
    run_scan(4'b0100, 4'b0100);

    // continuous scan with ignored mid-scan start
    set_sensor(0, 15, 25);
    set_sensor(1, 25, 35);
    continuous = 1'b1;
    d0 = done_cnt;
    repeat (3) push_scan(4'b0011);
    @(negedge clk); ch_enable = 4'b0011; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt < d0 + 2; i++) @(negedge clk);
    check_val("cont_two_scans", done_cnt - d0, 2);
    continuous = 1'b0;
    for (int i = 0; i < 3000 && done_cnt < d0 + 3; i++) @(negedge clk);
    check_val("cont_third_scan", done_cnt - d0, 3);
    repeat (100) @(negedge clk);
    check_val("cont_stopped_done", done_cnt - d0, 3);
    check_val("cont_stopped_active", active_out, 0);
    wait_quiet();

    // empty mask
    push_scan(4'b0000);
    @(negedge clk); ch_enable = 4'b0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("empty_done", scan_done_out, 1);
    check_val("empty_active", active_out, 0);
    check_val("empty_pulse", pulse_out, 0);
    @(negedge clk);
    check_val("empty_done_strobe", scan_done_out, 0);
    check_val("empty_active2", active_out, 0);

    // randomized scans with boundary echo lengths
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int sel, len;
        sel = $urandom_range(0, 9);
        case (sel)
          0: len = 0;
          1: len = 1;
          2: len = TIMEOUT_CYCLES - 1;
          3: len = TIMEOUT_CYCLES;
          4: len = TIMEOUT_CYCLES + 1;
          default: len = $urandom_range(2, 260);
        endcase
        set_sensor(c, $urandom_range(3, 120), len);
      end
      m = 4'($urandom_range(1, 15));
      run_scan(m, 4'($urandom_range(0, 15)));
    end

    check_val("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
